game_flow_sequencer: RTL and testbench
======================================

Name: game_flow_sequencer

Overview:
- Top-level game-flow controller: sequences the playfield through attract, serve-ready, play, life-lost and game-over phases.
- Owns the lives counter, the score accumulator and all frame-based pause timers.
- Drives the enables and overlay selects consumed by the object/paddle datapath and the game-over overlay renderer.
- Inputs are one-cycle event pulses from the collision logic plus the frame-sync pulse from the video timing generator.

Parameters:
START_LIVES, 3, lives loaded at new game (1..7)
READY_FRAMES, 60, frames spent in READY before serve (>=1)
LOST_FRAMES, 90, frames frozen after a miss with lives remaining (>=1)
GAMEOVER_FRAMES, 128, frames the game-over overlay is held before returning to IDLE (>=1)
SCORE_W, 16, score width in bits
POINTS_PER_HIT, 1, score increment per hit

Ports:
pixel_clk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
fsync  in  1  one-cycle pulse, once per frame
start_btn  in  1  start button level, already synchronised to pixel_clk
hit  in  1  one-cycle pulse: paddle returned the object
miss  in  1  one-cycle pulse: object passed the paddle line
state  out  3  current state encoding: IDLE=0, READY=1, PLAY=2, LIFE_LOST=3, GAMEOVER=4
play_en  out  1  object/paddle motion enabled
freeze  out  1  playfield frozen (LIFE_LOST or GAMEOVER)
show_ready  out  1  ready banner select
show_gameover  out  1  game-over overlay select
lives  out  3  remaining lives
score  out  SCORE_W  current score
new_game  out  1  one-cycle pulse on game start (datapath reset)
serve  out  1  one-cycle pulse on READY->PLAY (object respawn)

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, lives=START_LIVES, score=0, all flags and pulses 0, frame counter 0, start_q=1.
- Start edge detect: start_rise = start_btn & ~start_q; start_q <= start_btn every cycle. Because start_q resets to 1, a button held through reset does not start a game until it is released and pressed again.
- Frame counter (8 bit): cleared in the cycle any state transition is taken. Increments on fsync in timed states (READY, LIFE_LOST, GAMEOVER). An fsync in the transition cycle belongs to the old state and is not counted in the new one.
- Timed exit: a timed state leaves on the fsync where counter == N-1, giving exactly N fsyncs of residence.
- IDLE:
  - start_rise -> READY.
  - Same cycle: score<=0, lives<=START_LIVES, new_game pulses for 1 cycle.
- READY: after READY_FRAMES fsyncs -> PLAY; serve pulses in the transition cycle.
- PLAY, hit only: score <= score+POINTS_PER_HIT, saturating at 2^SCORE_W-1 (no wrap).
- PLAY, miss:
  - lives>1: lives-1, -> LIFE_LOST.
  - lives==1: lives<=0, -> GAMEOVER.
- PLAY, hit and miss in the same cycle: miss wins; score unchanged.
- LIFE_LOST: after LOST_FRAMES fsyncs -> READY (serve issued again on the next PLAY entry).
- GAMEOVER: after GAMEOVER_FRAMES fsyncs -> IDLE. Score and lives=0 are held through GAMEOVER and IDLE until the next new_game.
- Ignored inputs: hit/miss outside PLAY; start_rise outside IDLE.
- Decode (registered from next-state): play_en=PLAY; freeze=LIFE_LOST|GAMEOVER; show_ready=READY; show_gameover=GAMEOVER.
- Unused state encodings (5..7) -> IDLE next cycle.
- Asynchronous reset mid-game returns immediately to reset values; no pulse is emitted on reset release.

Test Plan:
- Reset release with start_btn held high -> remains IDLE, new_game=0. Release, then press -> new_game 1 cycle, state=1, lives=3, score=0.
- READY_FRAMES=4: 4 fsyncs after entry -> PLAY on 4th fsync cycle, serve 1 cycle, play_en=1. fsync in entry cycle not counted.
- PLAY: 5 hit pulses -> score=5. SCORE_W=4 starting at 14: 3 hits -> 15,15,15 (saturates).
- hit and miss same cycle at lives=3, score=7 -> lives=2, score=7, state=3, freeze=1. After LOST_FRAMES fsyncs -> state=1.
- Three misses from START_LIVES=3 -> lives=0, state=4, show_gameover=1. After GAMEOVER_FRAMES fsyncs -> IDLE, score held. start pulses during GAMEOVER ignored.
- Assert rst_n low mid-PLAY with score=9 -> state=0, score=0, lives=3, all flags 0 immediately; no serve/new_game pulse on release.

Source files
------------

// File: rtl/game_flow_sequencer.sv
// Game-flow controller: IDLE/READY/PLAY/LIFE_LOST/GAMEOVER sequencing, lives, score and frame pause timers.
// Every output is a flop that updates one cycle after its cause. Event pulses are always accepted (no backpressure).
module game_flow_sequencer #(
    parameter int START_LIVES     = 3,
    parameter int READY_FRAMES    = 60,
    parameter int LOST_FRAMES     = 90,
    parameter int GAMEOVER_FRAMES = 128,
    parameter int SCORE_W         = 16,
    parameter int POINTS_PER_HIT  = 1
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               fsync,
    input  logic               start_btn,
    input  logic               hit,
    input  logic               miss,
    output logic [2:0]         state,
    output logic               play_en,
    output logic               freeze,
    output logic               show_ready,
    output logic               show_gameover,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               new_game,
    output logic               serve
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_LOST     = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_e;

    localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);
    localparam logic [7:0]         READY_LAST = 8'(READY_FRAMES - 1);
    localparam logic [7:0]         LOST_LAST  = 8'(LOST_FRAMES - 1);
    localparam logic [7:0]         GO_LAST    = 8'(GAMEOVER_FRAMES - 1);
    localparam logic [SCORE_W:0]   SCORE_MAX  = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   PTS        = (SCORE_W + 1)'(POINTS_PER_HIT);

    state_e               state_q, state_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [2:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 start_q, start_d;
    logic                 new_game_q, new_game_d;
    logic                 serve_q, serve_d;
    logic                 play_en_q, play_en_d;
    logic                 freeze_q, freeze_d;
    logic                 show_ready_q, show_ready_d;
    logic                 show_gameover_q, show_gameover_d;

    logic                 start_rise;
    logic                 timed;
    logic                 timer_done;
    logic [7:0]           frame_last;
    logic [SCORE_W:0]     score_sum;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;
        score_d     = score_q;
        new_game_d  = 1'b0;
        serve_d     = 1'b0;
        start_d     = start_btn;
        start_rise  = start_btn & ~start_q;
        score_sum   = {1'b0, score_q} + PTS;
        timed       = 1'b0;
        frame_last  = '0;

        case (state_q)
            ST_READY:    begin timed = 1'b1; frame_last = READY_LAST; end
            ST_LOST:     begin timed = 1'b1; frame_last = LOST_LAST;  end
            ST_GAMEOVER: begin timed = 1'b1; frame_last = GO_LAST;    end
            default:     ;
        endcase

        // Exit on the fsync that completes the N-th frame of residence.
        timer_done = timed & fsync & (frame_cnt_q == frame_last);
        if (timed && fsync) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_READY;
                    score_d    = '0;
                    lives_d    = LIVES_INIT;
                    new_game_d = 1'b1;
                end
            end
            ST_READY: begin
                if (timer_done) begin
                    state_d = ST_PLAY;
                    serve_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = ST_LOST;
                    end else begin
                        lives_d = '0;
                        state_d = ST_GAMEOVER;
                    end
                end else if (hit) begin
                    score_d = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                      : score_sum[SCORE_W-1:0];
                end
            end
            ST_LOST: begin
                if (timer_done) state_d = ST_READY;
            end
            ST_GAMEOVER: begin
                if (timer_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The counter restarts for the new state; a coinciding fsync stays with the old one.
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end

        play_en_d       = (state_d == ST_PLAY);
        freeze_d        = (state_d == ST_LOST) || (state_d == ST_GAMEOVER);
        show_ready_d    = (state_d == ST_READY);
        show_gameover_d = (state_d == ST_GAMEOVER);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            frame_cnt_q     <= '0;
            lives_q         <= LIVES_INIT;
            score_q         <= '0;
            start_q         <= 1'b1;
            new_game_q      <= 1'b0;
            serve_q         <= 1'b0;
            play_en_q       <= 1'b0;
            freeze_q        <= 1'b0;
            show_ready_q    <= 1'b0;
            show_gameover_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_cnt_q     <= frame_cnt_d;
            lives_q         <= lives_d;
            score_q         <= score_d;
            start_q         <= start_d;
            new_game_q      <= new_game_d;
            serve_q         <= serve_d;
            play_en_q       <= play_en_d;
            freeze_q        <= freeze_d;
            show_ready_q    <= show_ready_d;
            show_gameover_q <= show_gameover_d;
        end
    end

    assign state         = state_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign new_game      = new_game_q;
    assign serve         = serve_q;
    assign play_en       = play_en_q;
    assign freeze        = freeze_q;
    assign show_ready    = show_ready_q;
    assign show_gameover = show_gameover_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Randomised bench for game_flow_sequencer: a phase-level game model predicts every output cycle,
// a monitor pops predictions after each clock edge (and on reset assertion) and compares.
module tb_game_flow_sequencer;

    localparam int SL  = 3;
    localparam int RF  = 4;
    localparam int LF  = 3;
    localparam int GF  = 5;
    localparam int SW  = 4;
    localparam int PPH = 1;

    typedef struct packed {
        logic [2:0]    state;
        logic          play_en;
        logic          freeze;
        logic          show_ready;
        logic          show_gameover;
        logic [2:0]    lives;
        logic [SW-1:0] score;
        logic          new_game;
        logic          serve;
    } obs_t;

    logic          clk = 1'b1;
    logic          rst_n = 1'b1;
    logic          fsync = 1'b0;
    logic          start_btn = 1'b1;
    logic          hit = 1'b0;
    logic          miss = 1'b0;
    logic [2:0]    state;
    logic          play_en, freeze, show_ready, show_gameover, new_game, serve;
    logic [2:0]    lives;
    logic [SW-1:0] score;

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    game_flow_sequencer #(
        .START_LIVES(SL), .READY_FRAMES(RF), .LOST_FRAMES(LF),
        .GAMEOVER_FRAMES(GF), .SCORE_W(SW), .POINTS_PER_HIT(PPH)
    ) dut (
        .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync), .start_btn(start_btn),
        .hit(hit), .miss(miss), .state(state), .play_en(play_en), .freeze(freeze),
        .show_ready(show_ready), .show_gameover(show_gameover), .lives(lives),
        .score(score), .new_game(new_game), .serve(serve)
    );

    always #5 clk = ~clk;

    // Game model: phase numbers are the externally visible state codes.
    int m_phase, m_frames, m_lives, m_score;
    bit m_btn_prev, m_new_game, m_serve;

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_lives = SL; m_score = 0;
        m_btn_prev = 1'b1; m_new_game = 1'b0; m_serve = 1'b0;
    endtask

    function automatic obs_t expect_now();
        obs_t e;
        e.state         = 3'(m_phase);
        e.play_en       = (m_phase == 2);
        e.freeze        = (m_phase == 3) || (m_phase == 4);
        e.show_ready    = (m_phase == 1);
        e.show_gameover = (m_phase == 4);
        e.lives         = 3'(m_lives);
        e.score         = SW'(m_score);
        e.new_game      = m_new_game;
        e.serve         = m_serve;
        return e;
    endfunction

    // Counts frames spent in the current phase; returns 1 when the phase's frame quota is used up.
    function automatic bit frame_quota_reached(input bit fs, input int quota);
        if (!fs) return 1'b0;
        m_frames++;
        return (m_frames >= quota);
    endfunction

    task automatic model_step(input bit fs, input bit st, input bit h, input bit ms);
        bit rise;
        rise = st && !m_btn_prev;
        m_btn_prev = st;
        m_new_game = 1'b0;
        m_serve = 1'b0;
        case (m_phase)
            0: if (rise) begin
                m_phase = 1; m_frames = 0; m_score = 0; m_lives = SL; m_new_game = 1'b1;
            end
            1: if (frame_quota_reached(fs, RF)) begin
                m_phase = 2; m_frames = 0; m_serve = 1'b1;
            end
            2: if (ms) begin
                m_lives = m_lives - 1;
                m_phase = (m_lives == 0) ? 4 : 3;
                m_frames = 0;
            end else if (h) begin
                m_score = m_score + PPH;
                if (m_score > (2 ** SW) - 1) m_score = (2 ** SW) - 1;
            end
            3: if (frame_quota_reached(fs, LF)) begin m_phase = 1; m_frames = 0; end
            4: if (frame_quota_reached(fs, GF)) begin m_phase = 0; m_frames = 0; end
            default: m_phase = 0;
        endcase
    endtask

    task automatic drive(input bit rn, input bit fs, input bit st, input bit h, input bit ms);
        @(negedge clk);
        if (!rn && rst_n) begin
            model_reset();
            exp_q.push_back(expect_now());
        end
        rst_n = rn; fsync = fs; start_btn = st; hit = h; miss = ms;
        if (!rn) model_reset();
        else     model_step(fs, st, h, ms);
        exp_q.push_back(expect_now());
    endtask

    always @(posedge clk or negedge rst_n) begin
        obs_t e, a;
        #1;
        a = '{state, play_en, freeze, show_ready, show_gameover, lives, score, new_game, serve};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow t=%0t actual st=%0d with no prediction queued", $time, a.state);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual st=%0d pe=%0b fr=%0b rdy=%0b go=%0b lv=%0d sc=%0d ng=%0b sv=%0b required st=%0d pe=%0b fr=%0b rdy=%0b go=%0b lv=%0d sc=%0d ng=%0b sv=%0b",
                         $time, a.state, a.play_en, a.freeze, a.show_ready, a.show_gameover, a.lives,
                         a.score, a.new_game, a.serve, e.state, e.play_en, e.freeze, e.show_ready,
                         e.show_gameover, e.lives, e.score, e.new_game, e.serve);
            end
        end
    end

    bit btn = 1'b0;

    initial begin
        bit fs, h, ms, reached;
        // Button held through reset and afterwards: no game may start.
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, i[0], 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        btn = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            fs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            ms = ($urandom_range(0, 19) == 0);
            h  = ($urandom_range(0, 9) < 4);
            drive(1'b1, fs, btn, h, ms);
        end

        // Reach PLAY with a nonzero score, then reset mid-game.
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            fs = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            drive(1'b1, fs, btn, 1'b1, 1'b0);
            reached = (m_phase == 2) && (m_score > 0);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reach_play actual phase=%0d score=%0d required PLAY with score>0", m_phase, m_score);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b1, i[0], 1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d predictions left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
